// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage: FIFOs an RGB888 stream, locks its sof to vsync and
// re-times hs/vs/de plus pixel by one clock toward the video output.
module vga_pixel_fetch #(
  parameter int   H_ACTIVE   = 640,
  parameter int   V_ACTIVE   = 480,
  parameter int   FIFO_DEPTH = 16,
  parameter logic VS_POL     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        underflow,
  output logic        frame_err
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT,
    ARMED,
    RUN
  } state_t;

  state_t state, state_d;

  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] lvl, lvl_d;
  logic [CW-1:0] cnt, cnt_d, cnt_eff;

  logic        vs_q, vs_start;
  logic        empty, head_sof;
  logic        wr, pop, flush;
  logic        uf, sof_err, cnt_err, vs_err;
  logic        rdy_q, rdy_d;
  logic [23:0] pix;

  assign empty    = (lvl == '0);
  assign head_sof = mem[rp][24];
  assign vs_start = (vs_in == VS_POL) && (vs_q != VS_POL);
  assign s_ready  = rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      HUNT:    if (wr)       state_d = ARMED;
      ARMED:   if (vs_start) state_d = RUN;
      RUN:     if (flush)    state_d = HUNT;
      default:               state_d = HUNT;
    endcase
  end

  // A vs_start coinciding with a pop counts that pop as pixel 0.
  always_comb begin
    cnt_eff = vs_start ? '0 : cnt;
    wr      = s_valid && rdy_q && ((state != HUNT) || s_sof);
    pop     = (state == RUN) && de_in && !empty;
    uf      = (state == RUN) && de_in && empty;
    sof_err = pop && (head_sof == (cnt_eff != '0));
    cnt_err = pop && !vs_start && (cnt == CNT_FULL);
    vs_err  = (state == RUN) && vs_start && (cnt != CNT_FULL);
    flush   = uf || sof_err || cnt_err || vs_err;
    pix     = '0;
    if (pop && !sof_err && !cnt_err) pix = mem[rp][23:0];
    lvl_d   = flush ? '0 : lvl + LW'(wr) - LW'(pop);
    cnt_d   = '0;
    if (state == RUN && !flush) cnt_d = cnt_eff + CW'(pop);
    rdy_d   = (state_d == HUNT) ? !flush : (lvl_d != LVL_FULL);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {s_sof, s_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      lvl   <= '0;
      cnt   <= '0;
      vs_q  <= ~VS_POL;
      rdy_q <= 1'b0;
    end else begin
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (wr)  wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
      end
      lvl   <= lvl_d;
      cnt   <= cnt_d;
      vs_q  <= vs_in;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
      de_out    <= 1'b0;
      rgb_r     <= '0;
      rgb_g     <= '0;
      rgb_b     <= '0;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      hs_out    <= hs_in;
      vs_out    <= vs_in;
      de_out    <= de_in;
      rgb_r     <= pix[23:16];
      rgb_g     <= pix[15:8];
      rgb_b     <= pix[7:0];
      underflow <= uf;
      frame_err <= sof_err || cnt_err || vs_err;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: small 8x4 raster, stream driver with
// optional random stalls, and a queue-based reference of the stage.
module tb_vga_pixel_fetch;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int TOT   = H * V;
  localparam int DEPTH = 16;
  localparam int PRE   = 20;
  localparam int LINE  = 12;
  localparam int FRM   = 6 * LINE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b1;
  logic        de_in = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        hs_out, vs_out, de_out;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic        underflow, frame_err;

  always #5 clk = ~clk;

  vga_pixel_fetch #(
    .H_ACTIVE(H), .V_ACTIVE(V),
    .FIFO_DEPTH(DEPTH), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .underflow(underflow), .frame_err(frame_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [24:0] src[$];
  logic [23:0] sent[$];
  logic [23:0] seen[$];
  int rd = 0;
  bit rand_stall = 0;

  // Upstream source: walks src in order, advancing on each handshake.
  bit took = 0;
  always @(negedge clk) begin
    if (!rst_n) rd = 0;
    else if (took) rd++;
    if (rd < src.size() &&
        !(rand_stall && $urandom_range(0, 3) == 0)) begin
      s_valid = 1'b1;
      {s_sof, s_data} = src[rd];
    end else begin
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = 24'($urandom);
    end
  end

  // Reference: FIFO as a queue, mode 0/1/2 = hunt/armed/run.
  logic [24:0] mq[$];
  logic [24:0] ent;
  int   mmode, mcnt, base, acc_cnt;
  bit   mvs, vst, acc, err;
  logic e_hs, e_vs, e_de, e_uf, e_fe, e_rdy;
  logic [23:0] e_rgb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mmode = 0; mcnt = 0; mvs = 1; took = 0; acc_cnt = 0;
      e_hs = 0; e_vs = 0; e_de = 0; e_rgb = '0;
      e_uf = 0; e_fe = 0; e_rdy = 0;
    end else begin
      took = s_valid && s_ready;
      acc_cnt += int'(took);
      acc = s_valid && e_rdy;
      vst = (vs_in == 1'b0) && mvs;
      mvs = vs_in;
      e_hs = hs_in; e_vs = vs_in; e_de = de_in;
      e_rgb = '0; e_uf = 0; e_fe = 0; err = 0;
      if (mmode == 2) begin
        base = vst ? 0 : mcnt;
        if (vst && mcnt != TOT) begin e_fe = 1; err = 1; end
        if (de_in) begin
          if (mq.size() == 0) begin
            e_uf = 1; err = 1;
          end else begin
            ent = mq.pop_front();
            if (ent[24] != (base == 0) || (!vst && mcnt == TOT)) begin
              e_fe = 1; err = 1;
            end else begin
              e_rgb = ent[23:0];
            end
            base++;
          end
        end
        mcnt = base;
      end
      if (acc && (mmode != 0 || s_sof)) mq.push_back({s_sof, s_data});
      if (mmode == 0 && acc && s_sof) mmode = 1;
      else if (mmode == 1 && vst) begin mmode = 2; mcnt = 0; end
      if (err) begin
        mq.delete(); mmode = 0; mcnt = 0; e_rdy = 0;
      end else begin
        e_rdy = (mmode == 0) || (mq.size() < DEPTH);
      end
    end
  end

  function automatic logic [29:0] dutv();
    return {hs_out, vs_out, de_out, rgb_r, rgb_g, rgb_b,
            underflow, frame_err, s_ready};
  endfunction

  function automatic logic [29:0] expv();
    return {e_hs, e_vs, e_de, e_rgb, e_uf, e_fe, e_rdy};
  endfunction

  // {hs, vs, de}: idle pre-roll, then vsync line, porch line, 4 active.
  function automatic logic [2:0] tim(int c);
    int p, l, x;
    if (c < PRE) return 3'b010;
    p = (c - PRE) % FRM;
    l = p / LINE;
    x = p % LINE;
    return {(x == 9 || x == 10), (l != 0), (l >= 2 && x < H)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    rand_stall = 0;
    src.delete();
    sent.delete();
    seen.delete();
    {hs_in, vs_in, de_in} = 3'b010;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_frame(int n, bit rnd, int b);
    logic [23:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 24'($urandom) : 24'(b + i);
      src.push_back({(i == 0), d});
      sent.push_back(d);
    end
  endtask

  task automatic test_normal();
    int nuf = 0, nfe = 0, bad = 0;
    do_reset();
    push_frame(TOT, 0, 0);
    push_frame(TOT, 0, 0);
    for (int c = 0; c < PRE + 2 * FRM + 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL normal cyc %0d dut %h model %h", c, dutv(), expv());
      end
      if (de_out) seen.push_back({rgb_r, rgb_g, rgb_b});
      nuf += int'(underflow);
      nfe += int'(frame_err);
      {hs_in, vs_in, de_in} = tim(c);
    end
    for (int i = 0; i < seen.size(); i++)
      if (seen[i] !== 24'(i % TOT)) bad++;
    n_chk++;
    if (seen.size() != 2 * TOT || bad != 0) begin
      n_fail++;
      $display("FAIL normal_ramp got %0d px %0d bad want %0d px 0 bad",
               seen.size(), bad, 2 * TOT);
    end
    n_chk++;
    if (nuf != 0 || nfe != 0) begin
      n_fail++;
      $display("FAIL normal_err got uf %0d fe %0d want 0 0", nuf, nfe);
    end
  endtask

  task automatic test_reset();
    do_reset();
    push_frame(TOT, 1, 0);
    for (int c = 0; c < PRE + 30; c++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL reset_pre cyc %0d dut %h model %h", c, dutv(), expv());
      end
      {hs_in, vs_in, de_in} = tim(c);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== 30'd0 || s_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold clk %0d got %h want 0", k, dutv());
      end
    end
    rst_n = 1'b1;
    {hs_in, vs_in, de_in} = 3'b010;
    @(negedge clk);
    n_chk++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b want 1", s_ready);
    end
    n_chk++;
    if (dutv() !== expv()) begin
      n_fail++;
      $display("FAIL reset_release dut %h model %h", dutv(), expv());
    end
  endtask

  task automatic test_presof();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 5; i++) src.push_back({1'b0, 24'($urandom)});
    push_frame(TOT, 1, 0);
    for (int c = 0; c < PRE + FRM + 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL presof cyc %0d dut %h model %h", c, dutv(), expv());
      end
      if (de_out) seen.push_back({rgb_r, rgb_g, rgb_b});
      {hs_in, vs_in, de_in} = tim(c);
    end
    n_chk++;
    if (seen.size() == 0 || seen[0] !== sent[0]) begin
      n_fail++;
      $display("FAIL presof_first got %h want %h",
               (seen.size() > 0) ? seen[0] : 24'hx, sent[0]);
    end
    for (int i = 0; i < seen.size(); i++)
      if (seen[i] !== sent[i]) bad++;
    n_chk++;
    if (seen.size() != TOT || bad != 0) begin
      n_fail++;
      $display("FAIL presof_frame got %0d px %0d bad want %0d px",
               seen.size(), bad, TOT);
    end
  endtask

  task automatic test_underflow();
    int nde = 0, c11 = -1, nuf = 0, ufc = -1, nfe = 0, bad = 0;
    logic [23:0] w;
    do_reset();
    push_frame(10, 0, 1);
    for (int c = 0; c < PRE + 2 * FRM + 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL underflow cyc %0d dut %h model %h", c, dutv(), expv());
      end
      if (de_out) seen.push_back({rgb_r, rgb_g, rgb_b});
      if (underflow) begin nuf++; ufc = c; end
      nfe += int'(frame_err);
      if (c == PRE + FRM - 6) push_frame(TOT, 0, 'h100);
      {hs_in, vs_in, de_in} = tim(c);
      if (de_in) begin
        nde++;
        if (nde == 11) c11 = c;
      end
    end
    n_chk++;
    if (nuf != 1 || ufc != c11 + 1) begin
      n_fail++;
      $display("FAIL underflow_pulse got %0d at %0d want 1 at %0d",
               nuf, ufc, c11 + 1);
    end
    n_chk++;
    if (nfe != 0) begin
      n_fail++;
      $display("FAIL underflow_fe got %0d want 0", nfe);
    end
    for (int i = 0; i < seen.size(); i++) begin
      w = (i < 10) ? 24'(i + 1) : (i < TOT) ? 24'd0 : 24'('h100 + i - TOT);
      if (seen[i] !== w) bad++;
    end
    n_chk++;
    if (seen.size() != 2 * TOT || bad != 0) begin
      n_fail++;
      $display("FAIL underflow_pixels got %0d px %0d bad want %0d px",
               seen.size(), bad, 2 * TOT);
    end
  endtask

  task automatic test_short();
    int nde = 0, c32 = -1, nfe = 0, fec = -1, nuf = 0, bad = 0;
    logic [23:0] w;
    do_reset();
    push_frame(TOT - 1, 1, 0);
    push_frame(TOT, 1, 0);
    for (int c = 0; c < PRE + 2 * FRM + 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL short cyc %0d dut %h model %h", c, dutv(), expv());
      end
      if (de_out) seen.push_back({rgb_r, rgb_g, rgb_b});
      if (frame_err) begin nfe++; fec = c; end
      nuf += int'(underflow);
      {hs_in, vs_in, de_in} = tim(c);
      if (de_in) begin
        nde++;
        if (nde == TOT) c32 = c;
      end
    end
    n_chk++;
    if (nfe != 1 || fec != c32 + 1) begin
      n_fail++;
      $display("FAIL short_frame_err got %0d at %0d want 1 at %0d",
               nfe, fec, c32 + 1);
    end
    n_chk++;
    if (nuf != 0) begin
      n_fail++;
      $display("FAIL short_uf got %0d want 0", nuf);
    end
    for (int i = 0; i < seen.size(); i++) begin
      w = (i < TOT - 1) ? sent[i] : 24'd0;
      if (seen[i] !== w) bad++;
    end
    n_chk++;
    if (seen.size() != 2 * TOT || bad != 0) begin
      n_fail++;
      $display("FAIL short_pixels got %0d px %0d bad want %0d px",
               seen.size(), bad, 2 * TOT);
    end
  endtask

  task automatic test_back_pressure();
    logic [2:0] seq [9] = '{3'b000, 3'b010, 3'b011, 3'b010, 3'b010,
                            3'b010, 3'b010, 3'b010, 3'b010};
    int rise = -1;
    do_reset();
    push_frame(40, 1, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL bp_fill cyc %0d dut %h model %h", c, dutv(), expv());
      end
    end
    n_chk++;
    if (acc_cnt != DEPTH || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full got %0d beats ready %b want %0d beats ready 0",
               acc_cnt, s_ready, DEPTH);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL bp_pop step %0d dut %h model %h", k, dutv(), expv());
      end
      if (s_ready && rise < 0) rise = k;
      if (de_out) seen.push_back({rgb_r, rgb_g, rgb_b});
      {hs_in, vs_in, de_in} = seq[k];
    end
    n_chk++;
    if (rise != 3) begin
      n_fail++;
      $display("FAIL bp_rise got step %0d want step 3", rise);
    end
    n_chk++;
    if (acc_cnt != DEPTH + 1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_one_more got %0d beats ready %b want %0d ready 0",
               acc_cnt, s_ready, DEPTH + 1);
    end
    n_chk++;
    if (seen.size() != 1 || seen[0] !== sent[0]) begin
      n_fail++;
      $display("FAIL bp_pixel got %0d px want 1 px %h", seen.size(), sent[0]);
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    rand_stall = 1;
    for (int c = 0; c < PRE + 6 * FRM; c++) begin
      @(negedge clk);
      n_chk++;
      if (dutv() !== expv()) begin
        n_fail++;
        $display("FAIL random cyc %0d dut %h model %h", c, dutv(), expv());
      end
      if (src.size() - rd < 40) begin
        len = $urandom_range(0, 5);
        len = (len == 0) ? TOT - 1 : (len == 1) ? TOT + 1 : TOT;
        push_frame(len, 1, 0);
      end
      {hs_in, vs_in, de_in} = tim(c);
    end
    rand_stall = 0;
  endtask

  initial begin
    test_normal();
    test_reset();
    test_presof();
    test_underflow();
    test_short();
    test_back_pressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
